// File: rtl/kbd_uart_pkg.sv
// kbd_uart_pkg: shared types and constants for the PS/2 to UART bridge.
// ps2_rx honours the optional PS2_PARITY_CHECK_EN macro.
package kbd_uart_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE,
    PS2_DATA,
    PS2_PARITY,
    PS2_STOP
  } ps2_state_t;

  localparam int DATA_BITS = 8;
  localparam int UART_BITS = 10;

  function automatic logic [31:0] baud_div(
    input logic [1:0]  cfg,
    input int unsigned clk_hz
  );
    logic [31:0] d;
    unique case (cfg)
      2'b00:   d = clk_hz / 4800;
      2'b01:   d = clk_hz / 9600;
      2'b10:   d = clk_hz / 19200;
      default: d = clk_hz / 38400;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronised PS/2 frame receiver with idle timeout.
// PS2_PARITY_CHECK_EN: when defined, frames need odd parity.
module ps2_rx
  import kbd_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic [7:0] kbd_code,
  output logic       byte_valid
);

  logic [1:0] kc_sync;
  logic [1:0] kd_sync;
  logic       kc_prev;
  logic       fall;
  logic       din;
  logic       par_ok;

  ps2_state_t state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [31:0] tmo;

  assign fall = kc_prev & ~kc_sync[1];
  assign din  = kd_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign kbd_code   = shreg;
  assign byte_valid = (state == PS2_STOP)
                    & fall & din & par_ok;

  // two-flop synchronisers and previous kbd_clk sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kc_sync <= 2'b11;
      kd_sync <= 2'b11;
      kc_prev <= 1'b1;
    end else begin
      kc_sync <= {kc_sync[0], kbd_clk};
      kd_sync <= {kd_sync[0], kbd_data};
      kc_prev <= kc_sync[1];
    end
  end

  // frame state machine; a stalled frame falls back to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= PS2_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tmo     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= 1'b0;
`endif
    end else begin
      if (state == PS2_IDLE || fall)
        tmo <= '0;
      else
        tmo <= tmo + 32'd1;
      unique case (state)
        PS2_IDLE: begin
          if (fall && !din) begin
            state   <= PS2_DATA;
            bit_cnt <= '0;
          end
        end
        PS2_DATA: begin
          if (fall) begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1))
              state <= PS2_PARITY;
          end
        end
        PS2_PARITY: begin
          if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= din;
`endif
            state <= PS2_STOP;
          end
        end
        PS2_STOP: begin
          if (fall)
            state <= PS2_IDLE;
        end
        default: state <= PS2_IDLE;
      endcase
      if (state != PS2_IDLE && !fall
          && tmo == TIMEOUT_CYC - 32'd1)
        state <= PS2_IDLE;
    end
  end

endmodule

// File: rtl/kbd_uart_bridge.sv
// kbd_uart_bridge: PS/2 scan codes retransmitted as 8N1 UART.
// PS2_PARITY_CHECK_EN (in ps2_rx) enables odd-parity filtering.
module kbd_uart_bridge
  import kbd_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  input  logic [1:0] br_cfg,
  input  logic       rxd,
  output logic       txd
);

  logic [7:0]  kbd_code;
  logic        byte_valid;

  logic        rxd_meta;
  logic        rxd_unused;

  logic [7:0]  buf_data;
  logic        buf_full;

  logic        tx_busy;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_bit;
  logic [31:0] tx_div;
  logic [31:0] tx_cnt;
  logic        bit_end;
  logic        frame_end;
  logic        tx_load;

  ps2_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_ps2_rx (
    .clk        (clk),
    .rst        (rst),
    .kbd_clk    (kbd_clk),
    .kbd_data   (kbd_data),
    .kbd_code   (kbd_code),
    .byte_valid (byte_valid)
  );

  assign bit_end   = tx_busy
                   && (tx_cnt == tx_div - 32'd1);
  assign frame_end = bit_end
                   && (tx_bit == 4'(UART_BITS - 1));
  assign tx_load   = buf_full
                   && (!tx_busy || frame_end);

  // reserved receive line, synchronised only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta   <= 1'b1;
      rxd_unused <= 1'b1;
    end else begin
      rxd_meta   <= rxd;
      rxd_unused <= rxd_meta;
    end
  end

  // one-byte holding buffer; unload frees it before a new load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (byte_valid && (tx_load || !buf_full)) begin
      buf_full <= 1'b1;
      buf_data <= kbd_code;
    end else if (tx_load) begin
      buf_full <= 1'b0;
    end
  end

  // 8N1 transmitter; divisor latched at frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      tx_sh   <= '0;
      tx_bit  <= '0;
      tx_div  <= '0;
      tx_cnt  <= '0;
      txd     <= 1'b1;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, buf_data};
      tx_bit  <= '0;
      tx_cnt  <= '0;
      tx_div  <= baud_div(br_cfg, CLK_HZ);
      txd     <= 1'b0;
    end else if (frame_end) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      txd     <= 1'b1;
    end else if (bit_end) begin
      tx_cnt  <= '0;
      tx_bit  <= tx_bit + 4'd1;
      txd     <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[8:1]};
    end else if (tx_busy) begin
      tx_cnt  <= tx_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_kbd_uart_bridge.sv
// tb_kbd_uart_bridge: scoreboard bench for the PS/2 to UART bridge.
// Scaled clock rate keeps UART frames short.
module tb_kbd_uart_bridge;

  localparam int unsigned CLK_HZ = 5_000_000;
  localparam int unsigned TMO    = 2000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       kbd_clk  = 1'b1;
  logic       kbd_data = 1'b1;
  logic       rxd      = 1'b1;
  logic [1:0] br_cfg   = 2'b11;
  logic       txd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_busy = 1'b0;

  logic [7:0] exp_q[$];
  int         starts[$];

  kbd_uart_bridge #(
    .CLK_HZ      (CLK_HZ),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .kbd_clk  (kbd_clk),
    .kbd_data (kbd_data),
    .br_cfg   (br_cfg),
    .rxd      (rxd),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] c);
    int baud;
    case (c)
      2'b00:   baud = 4800;
      2'b01:   baud = 9600;
      2'b10:   baud = 19200;
      default: baud = 38400;
    endcase
    return int'(CLK_HZ) / baud;
  endfunction

  // PS/2 device side: 100-unit kbd_clk period, data set while high
  task automatic ps2_send(
    input logic [7:0] d,
    input bit         bad_par,
    input int         nbits
  );
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd_data = f[i];
      #25;
      kbd_clk = 1'b0;
      #50;
      kbd_clk = 1'b1;
      #25;
    end
    kbd_data = 1'b1;
  endtask

  task automatic mon_frame();
    int         d;
    bit         have;
    int         terr;
    logic [7:0] e;
    logic [9:0] mid;
    logic [9:0] fst;
    logic [9:0] lst;
    d = div_of(br_cfg);
    mon_busy = 1'b1;
    starts.push_back(cyc);
    have = (exp_q.size() > 0);
    e = 8'h00;
    if (have) e = exp_q.pop_front();
    mid = '0;
    fst = '0;
    lst = '0;
    for (int c = 0; c < 10 * d; c++) begin
      if (c > 0) @(negedge clk);
      if (!rst) begin
        mon_busy = 1'b0;
        return;
      end
      if (c % d == d / 2) mid[c / d] = txd;
      if (c % d == 0)     fst[c / d] = txd;
      if (c % d == d - 1) lst[c / d] = txd;
    end
    terr = 0;
    for (int k = 0; k < 10; k++) begin
      if (fst[k] !== mid[k]) terr++;
      if (lst[k] !== mid[k]) terr++;
    end
    if (!have) begin
      chk("spurious_frame", 32'd1, 32'd0);
    end else begin
      chk("uart_byte", 32'(mid[8:1]), 32'(e));
      chk("start_stop", 32'({mid[9], mid[0]}), 32'd2);
      chk("bit_timing", terr, 0);
    end
    mon_busy = 1'b0;
  endtask

  // UART line monitor: frames begin at the first low txd sample
  initial begin
    forever begin
      @(negedge clk);
      if (rst && !txd) mon_frame();
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy)
           && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < 40000), 32'd1);
    repeat (300) @(negedge clk);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_idle"}, 32'(mon_busy), 32'd0);
  endtask

  initial begin
    int low;
    int n;
    int d;

    #1 rst = 1'b0;
    #10;
    chk("reset_txd", 32'(txd), 32'd1);
    #10 rst = 1'b1;

    low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!txd) low++;
    end
    chk("idle_low_cycles", low, 0);
    chk("idle_frames", starts.size(), 0);

    br_cfg = 2'b11;
    exp_q.push_back(8'h1C);
    ps2_send(8'h1C, 1'b0, 11);
    drain("br11");

    br_cfg = 2'b10;
    exp_q.push_back(8'hA5);
    ps2_send(8'hA5, 1'b0, 11);
    drain("br10");

    br_cfg = 2'b01;
    exp_q.push_back(8'h80);
    ps2_send(8'h80, 1'b0, 11);
    drain("br01");

    br_cfg = 2'b11;
`ifndef PS2_PARITY_CHECK_EN
    exp_q.push_back(8'h1C);
`endif
    ps2_send(8'h1C, 1'b1, 11);
    drain("bad_parity");

    br_cfg = 2'b00;
    starts.delete();
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h32);
    ps2_send(8'h1C, 1'b0, 11);
    ps2_send(8'h32, 1'b0, 11);
    ps2_send(8'h21, 1'b0, 11);
    drain("overflow");
    chk("overflow_frames", starts.size(), 2);
    if (starts.size() >= 2)
      chk("b2b_gap", starts[1] - starts[0],
          10 * div_of(2'b00));

    br_cfg = 2'b11;
    starts.delete();
    exp_q.push_back(8'h5A);
    ps2_send(8'h5A, 1'b0, 5);
    repeat (2500) @(negedge clk);
    ps2_send(8'h5A, 1'b0, 11);
    drain("timeout");
    chk("timeout_frames", starts.size(), 1);

    starts.delete();
    exp_q.push_back(8'h1C);
    ps2_send(8'h1C, 1'b0, 11);
    ps2_send(8'h32, 1'b0, 11);
    n = 0;
    while (starts.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_frame_started", starts.size(), 1);
    d = div_of(2'b11);
    if (starts.size() > 0) begin
      n = 0;
      while (cyc - starts[0] < 4 * d + d / 2
             && n < 4000) begin
        @(negedge clk);
        n++;
      end
    end
    rst = 1'b0;
    #1;
    chk("rst_txd_async", 32'(txd), 32'd1);
    #20 rst = 1'b1;
    low = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!txd) low++;
    end
    chk("rst_residual_low", low, 0);
    chk("rst_no_new_frame", starts.size(), 1);
    chk("rst_monitor_idle", 32'(mon_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
